fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32 core. Consumes pc_sel and target_pc from the execute stage's branch/jump resolution.
- Owns the PC and issues one-outstanding requests to instruction memory.
- Buffers returned words in a small prefetch FIFO that feeds decode.
- On redirect, flushes buffered and in-flight instructions and restarts fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
pc_sel  input  1  redirect request from branch/jump resolution (taken branch or jump)
target_pc  input  32  redirect address, valid when pc_sel=1
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ack  input  1  one-cycle response strobe; imem_rdata valid this cycle
imem_rdata  input  32  instruction word
if_valid  output  1  head FIFO entry valid for decode
if_ready  input  1  decode accepts (low = stall)
if_pc  output  32  PC of head entry
if_inst  output  32  instruction of head entry

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset (sampled high at a clk edge):
  - imem_req=0, if_valid=0, if_pc=0, if_inst=0.
  - fetch_pc=RESET_PC, FIFO empty, state IDLE, drop flag clear.
  - Reset overrides all inputs. A request outstanding at reset is abandoned, and imem_req drops the cycle after the reset edge; imem must tolerate an aborted request.
- States:
  - IDLE: no request. Go to REQ when occupancy+0 < FIFO_DEPTH.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On imem_ack: push {fetch_pc, imem_rdata} unless drop flag is set, then fetch_pc+=4 (mod 2^32, wraps to 0).
    - Next state is REQ if occupancy after push/pop is < FIFO_DEPTH, else IDLE.
  - Requests are never back-to-back in the same cycle as ack. A new request may assert the cycle after ack.
- Occupancy accounting: a request may issue only if FIFO count + 1 <= FIFO_DEPTH, counting the in-flight slot. The FIFO never overflows.
- Output handshake: if_valid = FIFO non-empty. Pop occurs when if_valid & if_ready. if_pc/if_inst hold the head entry stably while if_valid & !if_ready.
- Latency: ack at cycle t -> entry visible at if_valid in cycle t+1. No combinational path from imem_rdata to if_inst.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Redirect (pc_sel=1 at cycle t):
  - At the t edge: FIFO cleared, fetch_pc <= {target_pc[31:2],2'b00}. if_valid=0 in cycle t+1.
  - If imem_req=1 and imem_ack=0 in cycle t: keep imem_req high with the old imem_addr (bus rule), set the drop flag, discard that response on ack, then clear the flag. The first request to the target issues the cycle after that ack.
  - If imem_ack=1 in cycle t: that response is discarded and the target request issues at t+1.
  - If no request is outstanding: the target request issues at t+1.
- Simultaneous events:
  - pc_sel and a pop in the same cycle: flush wins; the pop is irrelevant.
  - pc_sel while if_ready=0: flush still occurs.
  - A second pc_sel while the drop flag is set: update fetch_pc to the newest target; the drop flag stays set.
- target_pc[1:0] is ignored (forced to 00). No misalignment exception is raised in this block.

Test Plan:
- Reset, then reset low, with imem ack 1 cycle after each req and if_ready=1 -> imem_addr sequence 0x0,0x4,0x8. if_valid first high 2 cycles after first req; if_pc 0x0,0x4,0x8 in order.
- if_ready=0 with FIFO_DEPTH=2 -> exactly 2 acks accepted, imem_req low afterwards. if_pc stays 0x0. Raise if_ready -> pops 0x0 then 0x4, fetch resumes at 0x8.
- Redirect with no outstanding request: pc_sel=1, target_pc=0x0000_0100 -> next cycle if_valid=0, imem_addr=0x100. First delivered if_pc=0x100.
- Redirect mid-request: imem_addr=0x8 held unacked, pc_sel=1 target 0x200, ack 3 cycles later with 0xDEADBEEF -> imem_addr remains 0x8 until ack, 0xDEADBEEF never appears on if_inst. Next request is 0x200.
- Wrap and alignment: RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0000_0000. pc_sel with target 0x103 -> fetch at 0x100.
- Reset asserted while imem_req=1 unacked -> cycle after the edge imem_req=0, if_valid=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- RV32 instruction-fetch stage.
// The unit owns the fetch PC and keeps at most one instruction-memory request
// outstanding. Returned words go into a small prefetch FIFO that feeds decode.
// A redirect from branch/jump resolution flushes the FIFO and restarts fetch
// at the word-aligned target. A response that is still in flight when the
// redirect arrives is dropped when it returns.
//
// Ports:
//   clk         core clock
//   reset       synchronous, active-high reset
//   pc_sel      redirect request (taken branch / jump)
//   target_pc   redirect address; bits [1:0] are ignored
//   imem_req    fetch request, held until imem_ack
//   imem_addr   fetch address, stable while imem_req=1
//   imem_ack    one-cycle response strobe
//   imem_rdata  instruction word, valid with imem_ack
//   if_valid    head FIFO entry valid for decode
//   if_ready    decode accepts the head entry
//   if_pc       PC of the head entry
//   if_inst     instruction of the head entry
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_sel,
  input  logic [31:0] target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic             drop_q, drop_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];
  logic [31:0]      inst_mem_q [FIFO_DEPTH];

  logic ack_fire;
  logic push;
  logic pop;

  // The low target bits carry no meaning for an aligned fetch.
  logic unused_target_lsb;
  assign unused_target_lsb = ^target_pc[1:0];

  // Next-state logic: FIFO bookkeeping, fetch PC, drop flag and request FSM.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    ack_fire = (state_q == REQ) && imem_ack;
    // A redirect in the same cycle makes both the returning word and the pop moot.
    push     = ack_fire && !drop_q && !pc_sel;
    pop      = (count_q != '0) && if_ready && !pc_sel;

    if (pc_sel) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {target_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // A redirect while a request is still unanswered poisons its response;
    // any response clears the flag because only one request can be in flight.
    if ((state_q == REQ) && !imem_ack && pc_sel) begin
      drop_d = 1'b1;
    end else if (ack_fire) begin
      drop_d = 1'b0;
    end

    // A request reserves a FIFO slot, so one may issue only while the
    // occupancy after this cycle leaves room for it.
    case (state_q)
      IDLE: begin
        if (count_d < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_d = (count_d < DEPTH_C) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The bus address changes only when a new request starts; an unanswered
    // request keeps its old address even across a redirect.
    if ((state_d == REQ) && ((state_q == IDLE) || imem_ack)) begin
      addr_d = fetch_pc_d;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = addr_q;
  assign if_valid  = (count_q != '0);
  // Head outputs read zero whenever nothing is buffered.
  assign if_pc     = if_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign if_inst   = if_valid ? inst_mem_q[rd_ptr_q] : '0;

  // The in-flight reservation guarantees a free slot for every push.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> ((count_q < DEPTH_C) || pop));

  // The bus address stays put until the outstanding request is answered.
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_ack) |=> (imem_addr == $past(imem_addr)));

  // Occupancy never exceeds the buffer size.
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= DEPTH_C);

endmodule
